// File: rtl/nw_pkg.sv
// Shared Needleman-Wunsch definitions: the fetch-sequencer state enum and the
// output-manager buffer slot codes used with `count`.
package nw_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdDiag,
        StRdUp,
        StRdLeft,
        StCapLeft,
        StPresent,
        StWaitAck,
        StDone
    } seq_state_e;

    localparam logic [1:0] SLOT_DIAG = 2'd0;
    localparam logic [1:0] SLOT_UP   = 2'd1;
    localparam logic [1:0] SLOT_LEFT = 2'd2;

endpackage

// File: rtl/score_fetch_sequencer_if.sv
// Bus bundle for score_fetch_sequencer.
//   Control side : start, sweep, i_in, j_in, cell_ack  (into the sequencer)
//   Score RAM    : ram_en, ram_addr                    (out of the sequencer)
//   Output mgr   : en_read, count, signal              (out of the sequencer)
//   Status       : cur_i, cur_j, busy, cell_valid, done, err
// modport master is the sequencer's view, slave is the surrounding system's.
interface score_fetch_sequencer_if #(
    parameter int unsigned N      = 16,
    parameter int unsigned IDX_W  = $clog2(N + 1),
    parameter int unsigned ADDR_W = $clog2((N + 1) * (N + 1))
);
    logic              start;
    logic              sweep;
    logic [IDX_W-1:0]  i_in;
    logic [IDX_W-1:0]  j_in;
    logic              cell_ack;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic              en_read;
    logic [1:0]        count;
    logic              signal;
    logic [IDX_W-1:0]  cur_i;
    logic [IDX_W-1:0]  cur_j;
    logic              busy;
    logic              cell_valid;
    logic              done;
    logic              err;

    modport master (
        input  start, sweep, i_in, j_in, cell_ack,
        output ram_en, ram_addr, en_read, count, signal,
        output cur_i, cur_j, busy, cell_valid, done, err
    );

    modport slave (
        output start, sweep, i_in, j_in, cell_ack,
        input  ram_en, ram_addr, en_read, count, signal,
        input  cur_i, cur_j, busy, cell_valid, done, err
    );
endinterface

// File: rtl/nw_cell_addr.sv
// Combinational score-RAM address generator for the three neighbours of cell
// (i, j) in a row-major (N+1)x(N+1) matrix with stride N+1.
//   i_i, j_i  : cell indices
//   diag_o    : (i-1)*S + (j-1)
//   up_o      : (i-1)*S + j
//   left_o    : i*S + (j-1)
// Arithmetic is done at ADDR_W; out-of-range indices simply wrap.
module nw_cell_addr #(
    parameter int unsigned N      = 16,
    parameter int unsigned IDX_W  = $clog2(N + 1),
    parameter int unsigned ADDR_W = $clog2((N + 1) * (N + 1))
) (
    input  logic [IDX_W-1:0]  i_i,
    input  logic [IDX_W-1:0]  j_i,
    output logic [ADDR_W-1:0] diag_o,
    output logic [ADDR_W-1:0] up_o,
    output logic [ADDR_W-1:0] left_o
);
    localparam logic [ADDR_W-1:0] One    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] Stride = ADDR_W'(N + 1);

    logic [ADDR_W-1:0] i_w, j_w, row_prev, row_cur;

    always_comb begin
        i_w      = ADDR_W'(i_i);
        j_w      = ADDR_W'(j_i);
        row_prev = (i_w - One) * Stride;
        row_cur  = i_w * Stride;
        diag_o   = row_prev + j_w - One;
        up_o     = row_prev + j_w;
        left_o   = row_cur + j_w - One;
    end
endmodule

// File: rtl/score_fetch_sequencer.sv
// Fetches the diag/up/left neighbour scores of a Needleman-Wunsch cell from
// the score RAM into the output manager, for one cell or a row-major sweep.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : score_fetch_sequencer_if.master (control, RAM read, output manager)
// Optional build macro SCORE_FETCH_BOUNDS_EN: reject single-cell requests whose
// indices fall outside 1..N with a one-cycle `err` pulse.
module score_fetch_sequencer
    import nw_pkg::*;
#(
    parameter int unsigned N      = 16,
    parameter int unsigned IDX_W  = $clog2(N + 1),
    parameter int unsigned ADDR_W = $clog2((N + 1) * (N + 1))
) (
    input  logic                    clk,
    input  logic                    rst,
    score_fetch_sequencer_if.master bus
);
    localparam logic [IDX_W-1:0] IdxOne = IDX_W'(1);
    localparam logic [IDX_W-1:0] IdxN   = IDX_W'(N);

    seq_state_e       state_q, state_d;
    logic             sweep_q, sweep_d;
    logic [IDX_W-1:0] cur_i_q, cur_i_d;
    logic [IDX_W-1:0] cur_j_q, cur_j_d;
    logic             reject;

    logic [ADDR_W-1:0] diag_addr, up_addr, left_addr;

    nw_cell_addr #(
        .N      (N),
        .IDX_W  (IDX_W),
        .ADDR_W (ADDR_W)
    ) u_cell_addr (
        .i_i    (cur_i_q),
        .j_i    (cur_j_q),
        .diag_o (diag_addr),
        .up_o   (up_addr),
        .left_o (left_addr)
    );

`ifdef SCORE_FETCH_BOUNDS_EN
    logic err_q;

    always_comb begin
        reject = !bus.sweep && (bus.i_in == '0 || bus.j_in == '0 ||
                                bus.i_in > IdxN || bus.j_in > IdxN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == StIdle) && bus.start && reject;
        end
    end

    assign bus.err = err_q;
`else
    assign reject  = 1'b0;
    assign bus.err = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        cur_i_d = cur_i_q;
        cur_j_d = cur_j_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start && !reject) begin
                    sweep_d = bus.sweep;
                    cur_i_d = bus.sweep ? IdxOne : bus.i_in;
                    cur_j_d = bus.sweep ? IdxOne : bus.j_in;
                    state_d = StRdDiag;
                end
            end
            StRdDiag:  state_d = StRdUp;
            StRdUp:    state_d = StRdLeft;
            StRdLeft:  state_d = StCapLeft;
            StCapLeft: state_d = StPresent;
            StPresent: state_d = StWaitAck;
            StWaitAck: begin
                if (bus.cell_ack) begin
                    if (!sweep_q || (cur_i_q == IdxN && cur_j_q == IdxN)) begin
                        state_d = StDone;
                    end else begin
                        // Row-major advance: wrap j back to column 1 at end of row
                        if (cur_j_q == IdxN) begin
                            cur_j_d = IdxOne;
                            cur_i_d = cur_i_q + IdxOne;
                        end else begin
                            cur_j_d = cur_j_q + IdxOne;
                        end
                        state_d = StRdDiag;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            sweep_q <= 1'b0;
            cur_i_q <= '0;
            cur_j_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            cur_i_q <= cur_i_d;
            cur_j_q <= cur_j_d;
        end
    end

    // Outputs decode from state only, so reset clears them asynchronously.
    // RAM latency is one cycle: each read is captured by en_read one state later.
    always_comb begin
        bus.ram_en     = 1'b0;
        bus.ram_addr   = '0;
        bus.en_read    = 1'b0;
        bus.count      = SLOT_DIAG;
        bus.signal     = 1'b0;
        bus.cell_valid = 1'b0;
        bus.done       = 1'b0;
        unique case (state_q)
            StRdDiag: begin
                bus.ram_en   = 1'b1;
                bus.ram_addr = diag_addr;
            end
            StRdUp: begin
                bus.ram_en   = 1'b1;
                bus.ram_addr = up_addr;
                bus.en_read  = 1'b1;
                bus.count    = SLOT_DIAG;
            end
            StRdLeft: begin
                bus.ram_en   = 1'b1;
                bus.ram_addr = left_addr;
                bus.en_read  = 1'b1;
                bus.count    = SLOT_UP;
            end
            StCapLeft: begin
                bus.en_read = 1'b1;
                bus.count   = SLOT_LEFT;
            end
            StPresent: bus.signal = 1'b1;
            StWaitAck: begin
                bus.signal     = 1'b1;
                bus.cell_valid = 1'b1;
            end
            StDone:  bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy  = (state_q != StIdle);
    assign bus.cur_i = cur_i_q;
    assign bus.cur_j = cur_j_q;
endmodule
